// File: rtl/xadc_scan_controller.sv
// xadc_scan_controller: sequences XADC DRP config/convert/read for NCH aux channels
// Ports:
//   Clk_i, Reset_n_i (async active-low), Trigger_i (scan start pulse)
//   ADC_Busy_i, ADC_EOC_i, Data_Rdy_i, ADC_Data_in_i : XADC BUSY/EOC/DRDY/DO
//   Data_En_o, Data_Wr_o, ADC_SC_o, ADC_Address_o, ADC_Data_wr_o : XADC DEN/DWE/CONVST/DADDR/DI
//   Ch_Data_o (12 bits per channel), Ch_Valid_o (sticky per channel)
//   Scan_Done_o, Scan_Busy_o, Overrun_o, Timeout_Err_o : status
// Define XADC_AVG_EN to store the running average (old+new)>>1 instead of the raw sample.
module xadc_scan_controller #(
  parameter int          NCH          = 4,
  parameter int          FIRST_AUX    = 6,
  parameter int          TIMEOUT_CLKS = 4096,
  parameter logic [10:0] CFG0_UPPER   = 11'h000
) (
  input  logic              Clk_i,
  input  logic              Reset_n_i,
  input  logic              Trigger_i,
  input  logic              ADC_Busy_i,
  input  logic              ADC_EOC_i,
  input  logic              Data_Rdy_i,
  input  logic [15:0]       ADC_Data_in_i,
  output logic              Data_En_o,
  output logic              Data_Wr_o,
  output logic              ADC_SC_o,
  output logic [6:0]        ADC_Address_o,
  output logic [15:0]       ADC_Data_wr_o,
  output logic [12*NCH-1:0] Ch_Data_o,
  output logic [NCH-1:0]    Ch_Valid_o,
  output logic              Scan_Done_o,
  output logic              Scan_Busy_o,
  output logic              Overrun_o,
  output logic              Timeout_Err_o
);
  localparam int KW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  typedef enum logic [2:0] {IDLE, CFG_WR, CFG_WAIT, CONV, WAIT_EOC, RD, RD_WAIT, NEXT} state_t;
  state_t            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [TW-1:0]     wcnt_q, wcnt_d;
  logic              den_q, den_d, dwe_q, dwe_d, sc_q, sc_d;
  logic              done_q, done_d, ovr_q, ovr_d, tmo_q, tmo_d;
  logic [6:0]        addr_q, addr_d;
  logic [15:0]       di_q, di_d;
  logic [12*NCH-1:0] ch_q, ch_d;
  logic [NCH-1:0]    vld_q, vld_d;
  logic              waiting, evt, load;
  logic [11:0]       smp;
  logic [4:0]        cfg_ch;
  logic [6:0]        rd_addr;
  logic              unused_lsbs;
`ifdef XADC_AVG_EN
  logic [12:0]       avg_sum;
`endif
  assign waiting     = state_q inside {CFG_WAIT, WAIT_EOC, RD_WAIT};
  assign evt         = (state_q == WAIT_EOC) ? ADC_EOC_i : Data_Rdy_i;
  assign smp         = ADC_Data_in_i[15:4];
  assign unused_lsbs = ^ADC_Data_in_i[3:0];
  // Addresses follow the channel about to be accessed, since outputs are registered from next state.
  assign cfg_ch      = 5'(16 + FIRST_AUX) + 5'(k_d);
  assign rd_addr     = 7'(16 + FIRST_AUX) + 7'(k_d);
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    wcnt_d  = waiting ? wcnt_q + 1'b1 : '0;
    ch_d    = ch_q;
    vld_d   = vld_q;
    done_d  = 1'b0;
    tmo_d   = tmo_q;
    ovr_d   = ovr_q | (Trigger_i && state_q != IDLE);
    load    = 1'b0;
`ifdef XADC_AVG_EN
    avg_sum = '0;
`endif
    case (state_q)
      IDLE:     if (Trigger_i && !ADC_Busy_i) begin
                  state_d = CFG_WR;
                  k_d     = '0;
                end
      CFG_WR:   state_d = CFG_WAIT;
      CFG_WAIT: if (Data_Rdy_i) state_d = CONV;
      CONV:     state_d = WAIT_EOC;
      WAIT_EOC: if (ADC_EOC_i) state_d = RD;
      RD:       state_d = RD_WAIT;
      RD_WAIT:  if (Data_Rdy_i) begin
                  state_d = NEXT;
                  load    = 1'b1;
                end
      NEXT:     if (k_q == KW'(NCH - 1)) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
                end else begin
                  state_d = CFG_WR;
                  k_d     = k_q + 1'b1;
                end
    endcase
    // Counter value TIMEOUT_CLKS-1 here means this edge would make TIMEOUT_CLKS idle cycles.
    if (waiting && !evt && wcnt_q == TW'(TIMEOUT_CLKS - 1)) begin
      state_d = IDLE;
      tmo_d   = 1'b1;
    end
    for (int c = 0; c < NCH; c++) begin
      if (load && k_q == KW'(c)) begin
`ifdef XADC_AVG_EN
        avg_sum          = {1'b0, ch_q[12*c +: 12]} + {1'b0, smp};
        ch_d[12*c +: 12] = vld_q[c] ? avg_sum[12:1] : smp;
`else
        ch_d[12*c +: 12] = smp;
`endif
        vld_d[c] = 1'b1;
      end
    end
    den_d  = state_d inside {CFG_WR, RD};
    dwe_d  = state_d == CFG_WR;
    sc_d   = state_d == CONV;
    addr_d = (state_d == CFG_WR) ? 7'h40 : (state_d == RD) ? rd_addr : '0;
    di_d   = (state_d == CFG_WR) ? {CFG0_UPPER, cfg_ch} : '0;
  end
  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      state_q <= IDLE;
      k_q     <= '0;
      wcnt_q  <= '0;
      den_q   <= 1'b0;
      dwe_q   <= 1'b0;
      sc_q    <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      tmo_q   <= 1'b0;
      addr_q  <= '0;
      di_q    <= '0;
      ch_q    <= '0;
      vld_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      wcnt_q  <= wcnt_d;
      den_q   <= den_d;
      dwe_q   <= dwe_d;
      sc_q    <= sc_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      tmo_q   <= tmo_d;
      addr_q  <= addr_d;
      di_q    <= di_d;
      ch_q    <= ch_d;
      vld_q   <= vld_d;
    end
  end
  assign Data_En_o     = den_q;
  assign Data_Wr_o     = dwe_q;
  assign ADC_SC_o      = sc_q;
  assign ADC_Address_o = addr_q;
  assign ADC_Data_wr_o = di_q;
  assign Ch_Data_o     = ch_q;
  assign Ch_Valid_o    = vld_q;
  assign Scan_Done_o   = done_q;
  assign Scan_Busy_o   = state_q != IDLE;
  assign Overrun_o     = ovr_q;
  assign Timeout_Err_o = tmo_q;
endmodule

// File: tb/tb_xadc_scan_controller.sv
// tb_xadc_scan_controller: self-checking bench with a behavioural XADC and scan reference model
module tb_xadc_scan_controller;
  localparam int          FA = 6;
  localparam logic [10:0] CU = 11'h5A5;
  logic        clk = 0, rst_n = 0, trig = 0, busy = 0, eoc = 0, rdy = 0;
  logic [15:0] din = '0;
  logic        den, dwe, sc, done, sbusy, ovr, tmo;
  logic [6:0]  addr;
  logic [15:0] di;
  logic [23:0] chd;
  logic [1:0]  chv;
  logic        trig1 = 0, eoc1 = 0, rdy1 = 0;
  logic [15:0] din1 = 16'h7770;
  logic        den1, dwe1, sc1, done1, sbusy1, ovr1, tmo1;
  logic [6:0]  addr1;
  logic [15:0] di1;
  logic [11:0] chd1;
  logic [0:0]  chv1;
  xadc_scan_controller #(.NCH(2), .FIRST_AUX(FA), .TIMEOUT_CLKS(16), .CFG0_UPPER(CU)) u0 (
    .Clk_i(clk), .Reset_n_i(rst_n), .Trigger_i(trig), .ADC_Busy_i(busy), .ADC_EOC_i(eoc),
    .Data_Rdy_i(rdy), .ADC_Data_in_i(din), .Data_En_o(den), .Data_Wr_o(dwe), .ADC_SC_o(sc),
    .ADC_Address_o(addr), .ADC_Data_wr_o(di), .Ch_Data_o(chd), .Ch_Valid_o(chv),
    .Scan_Done_o(done), .Scan_Busy_o(sbusy), .Overrun_o(ovr), .Timeout_Err_o(tmo));
  xadc_scan_controller #(.NCH(1), .FIRST_AUX(3)) u1 (
    .Clk_i(clk), .Reset_n_i(rst_n), .Trigger_i(trig1), .ADC_Busy_i(1'b0), .ADC_EOC_i(eoc1),
    .Data_Rdy_i(rdy1), .ADC_Data_in_i(din1), .Data_En_o(den1), .Data_Wr_o(dwe1), .ADC_SC_o(sc1),
    .ADC_Address_o(addr1), .ADC_Data_wr_o(di1), .Ch_Data_o(chd1), .Ch_Valid_o(chv1),
    .Scan_Done_o(done1), .Scan_Busy_o(sbusy1), .Overrun_o(ovr1), .Timeout_Err_o(tmo1));
  always #5 clk = ~clk;
  typedef struct {logic wr; logic [6:0] addr; logic [15:0] di;} txn_t;
  typedef struct {logic [15:0] d0, d1; int dr, de; logic [11:0] e0, e1;} vec_t;
  txn_t        log_q[$];
  txn_t        t;
  logic [15:0] rd_vals [2];
  int          dcnt = -1, ecnt = -1, drdy_dly = 0, eoc_dly = 0, proto_err = 0, done_cnt = 0;
  bit          eoc_mute = 0, spur = 0;
  int          n_chk = 0, n_fail = 0;
  logic [11:0] exp_ch [2];
  logic [1:0]  exp_v;
  // Behavioural XADC: DRDY drdy_dly cycles after DEN, EOC eoc_dly cycles after CONVST.
  always @(posedge clk) begin
    if (!rst_n) begin
      dcnt = -1;
      ecnt = -1;
      rdy <= 1'b0;
      eoc <= 1'b0;
    end else begin
      if (den) begin
        if (dcnt >= 0) proto_err++;
        t.wr = dwe;
        t.addr = addr;
        t.di = di;
        log_q.push_back(t);
        if (!dwe && int'(addr) >= 'h16 && int'(addr) <= 'h17) din <= rd_vals[int'(addr) - 'h16];
        dcnt = drdy_dly;
      end else if (dcnt >= 0) dcnt--;
      rdy <= (dcnt == 0) || spur;
      if (sc) ecnt = eoc_dly;
      else if (ecnt >= 0) ecnt--;
      eoc <= ((ecnt == 0) && !eoc_mute) || spur;
      if (done) done_cnt++;
    end
  end
  always @(posedge clk) begin
    rdy1 <= den1;
    eoc1 <= sc1;
  end
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic model_clear();
    exp_ch[0] = '0;
    exp_ch[1] = '0;
    exp_v = '0;
    log_q.delete();
    done_cnt = 0;
  endtask
  function automatic void model_load(input int k, input logic [15:0] raw);
    logic [11:0] s = raw[15:4];
`ifdef XADC_AVG_EN
    exp_ch[k] = exp_v[k] ? 12'((int'(exp_ch[k]) + int'(s)) / 2) : s;
`else
    exp_ch[k] = s;
`endif
    exp_v[k] = 1'b1;
  endfunction
  task automatic check_scan_log(input string tag);
    check($sformatf("%s txn count", tag), log_q.size(), 4);
    for (int i = 0; i < 4 && i < log_q.size(); i++) begin
      logic       w = (i % 2) == 0;
      logic [4:0] ch = 5'(16 + FA + i / 2);
      check($sformatf("%s txn%0d", tag, i),
            {log_q[i].wr, log_q[i].addr, log_q[i].wr ? log_q[i].di : 16'h0},
            {w, w ? 7'h40 : {2'b00, ch}, w ? {CU, ch} : 16'h0});
    end
  endtask
  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 300) begin
      tick();
      n++;
    end
    check($sformatf("%s done seen", tag), done, 1);
    tick();
  endtask
  task automatic run_scan(input logic [15:0] v0, input logic [15:0] v1, input int dr, input int de, input string tag);
    rd_vals[0] = v0;
    rd_vals[1] = v1;
    drdy_dly = dr;
    eoc_dly = de;
    log_q.delete();
    done_cnt = 0;
    trig = 1;
    tick();
    trig = 0;
    wait_done(tag);
    model_load(0, v0);
    model_load(1, v1);
    check_scan_log(tag);
    check($sformatf("%s ch_data", tag), chd, {exp_ch[1], exp_ch[0]});
    check($sformatf("%s ch_valid", tag), chv, exp_v);
    check($sformatf("%s done pulses", tag), done_cnt, 1);
    check($sformatf("%s busy after", tag), sbusy, 0);
  endtask
  task automatic check_zero(input string tag);
    check($sformatf("%s ctl", tag), {den, dwe, sc, done, sbusy, ovr, tmo}, 0);
    check($sformatf("%s addr/di", tag), {addr, di}, 0);
    check($sformatf("%s ch", tag), {chd, chv}, 0);
  endtask
  vec_t tbl [4];
  initial begin
    int n;
    logic [23:0] sv_d;
    logic [1:0]  sv_v;
    tbl[0] = '{16'hABC0, 16'hABC0, 0, 0, 12'hABC, 12'hABC};
`ifdef XADC_AVG_EN
    tbl[1] = '{16'h1000, 16'h0FF0, 0, 0, 12'h5DE, 12'h5DD};
    tbl[2] = '{16'h2000, 16'hFFFF, 2, 3, 12'h3EF, 12'hAEE};
    tbl[3] = '{16'h0000, 16'h0005, 1, 1, 12'h1F7, 12'h577};
`else
    tbl[1] = '{16'h1000, 16'h0FF0, 0, 0, 12'h100, 12'h0FF};
    tbl[2] = '{16'h2000, 16'hFFFF, 2, 3, 12'h200, 12'hFFF};
    tbl[3] = '{16'h0000, 16'h0005, 1, 1, 12'h000, 12'h000};
`endif
    model_clear();
    tick(2);
    check_zero("reset");
    check("u1 reset", {den1, sc1, done1, sbusy1, addr1, di1, chd1, chv1}, 0);
    rst_n = 1;
    tick();
    for (int i = 0; i < 4; i++) begin
      run_scan(tbl[i].d0, tbl[i].d1, tbl[i].dr, tbl[i].de, $sformatf("tbl%0d", i));
      check($sformatf("tbl%0d const", i), chd, {tbl[i].e1, tbl[i].e0});
    end
    rst_n = 0;
    tick(2);
    rst_n = 1;
    model_clear();
    tick();
    run_scan(16'h1000, 16'h0000, 0, 0, "avg1");
    check("avg first", chd[11:0], 12'h100);
    run_scan(16'h2000, 16'h0000, 1, 0, "avg2");
`ifdef XADC_AVG_EN
    check("avg second", chd[11:0], 12'h180);
`else
    check("avg second", chd[11:0], 12'h200);
`endif
    for (int i = 0; i < 20; i++)
      run_scan(16'($urandom), 16'($urandom), $urandom_range(0, 4), $urandom_range(0, 4), $sformatf("rnd%0d", i));
    log_q.delete();
    busy = 1;
    trig = 1;
    tick();
    trig = 0;
    tick(4);
    busy = 0;
    check("busy ignore scan", {sbusy, 1'(log_q.size() != 0)}, 0);
    check("busy ignore ovr", ovr, 0);
    spur = 1;
    tick();
    spur = 0;
    tick(3);
    check("spurious idle", {sbusy, 1'(log_q.size() != 0)}, 0);
    check("spurious data", {chd, chv}, {exp_ch[1], exp_ch[0], exp_v});
    rd_vals[0] = 16'h1230;
    rd_vals[1] = 16'h4560;
    drdy_dly = 0;
    eoc_dly = 0;
    log_q.delete();
    done_cnt = 0;
    trig = 1;
    tick();
    trig = 0;
    tick(2);
    trig = 1;
    tick();
    trig = 0;
    wait_done("ovr");
    tick(20);
    model_load(0, 16'h1230);
    model_load(1, 16'h4560);
    check("overrun flag", ovr, 1);
    check("overrun one scan", done_cnt, 1);
    check_scan_log("ovr");
    check("ovr ch_data", chd, {exp_ch[1], exp_ch[0]});
    sv_d = chd;
    sv_v = chv;
    eoc_mute = 1;
    done_cnt = 0;
    trig = 1;
    tick();
    trig = 0;
    n = 0;
    while (!sc && n < 50) begin
      tick();
      n++;
    end
    check("tmo conv seen", sc, 1);
    n = 0;
    while (!tmo && n < 40) begin
      tick();
      n++;
    end
    check("tmo latency", n, 17);
    tick(3);
    check("tmo sticky", tmo, 1);
    check("tmo idle", sbusy, 0);
    check("tmo no done", done_cnt, 0);
    check("tmo data kept", {chd, chv}, {sv_d, sv_v});
    eoc_mute = 0;
    drdy_dly = 4;
    trig = 1;
    tick();
    trig = 0;
    n = 0;
    while (!(den && !dwe) && n < 50) begin
      tick();
      n++;
    end
    check("rst read seen", {den, dwe}, 2'b10);
    tick();
    #2 rst_n = 0;
    #1 check_zero("async rst");
    tick(2);
    check_zero("rst held");
    rst_n = 1;
    model_clear();
    tick();
    check_zero("rst released");
    run_scan(16'h5550, 16'hAAA0, 1, 2, "post rst");
    trig1 = 1;
    tick();
    trig1 = 0;
    n = 0;
    while (!done1 && n < 30) begin
      tick();
      n++;
    end
    check("single ch latency", n, 7);
    check("single ch data", {chv1, chd1}, {1'b1, 12'h777});
    check("drp protocol", proto_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
